uart_tx: RTL and testbench

//   Buffered, parametrised UART transmitter for the RV32IM core's 9-bit {valid,data} console strobe.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and counter-width helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;
  function automatic int ctr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO queueing bytes ahead of the serialiser
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Occupancy moves by push minus pop; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // Pointers wrap naturally at DEPTH; reset flushes the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_d;
    end
  end
  // Storage array has no reset; only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter; even parity bit enabled by macro UART_TX_PARITY_EN
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          tx_busy
);
  localparam int BW = ctr_w(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = ctr_w(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 overflow_q;
  logic                 pop, empty;
  logic [DATA_BITS-1:0] head;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (wr_en),
    .pop_i   (pop),
    .data_i  (wr_data),
    .data_o  (head),
    .full_o  (wr_full),
    .empty_o (empty),
    .count_o (fifo_count)
  );
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign overflow = overflow_q;
  // Frame sequencer: each bit held CLKS_PER_BIT cycles; back-to-back frames pop at the last stop cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          bit_d   = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      ST_START: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_d   = bit_q + IW'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            bit_d   = '0;
            state_d = ST_START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end
  // Sequencer registers; reset truncates any frame in flight and idles the line high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= state_d != ST_IDLE;
    end
  end
`ifdef UART_TX_PARITY_EN
  // Parity of the frame being sent, captured when its byte leaves the FIFO.
  always_ff @(posedge clock) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif
  // Sticky flag for any write lost to a full FIFO.
  always_ff @(posedge clock) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_q | (wr_en & wr_full);
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a line decoder and expected-byte scoreboard
module tb_uart_tx;
  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME  = (1 + DB + PB + 1) * CPB;
  localparam int FRAME2 = (1 + DB + PB + 2) * CPB;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_full, overflow, tx, tx_busy;
  logic [4:0] fifo_count;
  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data2 = '0;
  logic       wr_full2, overflow2, tx2, tx_busy2;
  logic [4:0] fifo_count2;
  int         pass_cnt = 0;
  int         total = 0;
  int         cyc = 0;
  logic [7:0] sb [$];
  int         starts [$];
  logic       mon_en = 1'b1;
  logic       last_par = 1'b0;
  logic [7:0] mb;
  typedef struct {
    logic [7:0] d;
    logic       p;
  } vec_t;
  vec_t vecs [6];

  uart_tx #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .fifo_count(fifo_count), .overflow(overflow), .tx(tx), .tx_busy(tx_busy));
  uart_tx #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .clock(clock), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2), .wr_full(wr_full2),
    .fifo_count(fifo_count2), .overflow(overflow2), .tx(tx2), .tx_busy(tx_busy2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    sb.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((sb.size() != 0 || tx_busy) && n < budget) begin
      tick();
      n++;
    end
    check(name, {31'd0, sb.size() == 0 && !tx_busy}, 32'd1);
    repeat (4) tick();
  endtask

  // Line decoder: samples each bit at its centre on the falling clock edge.
  initial forever begin
    @(negedge clock);
    if (mon_en && !reset && tx === 1'b0) begin
      starts.push_back(cyc);
      repeat (2) @(negedge clock);
      check("start_bit", {31'd0, tx}, 32'd0);
      for (int i = 0; i < DB; i++) begin
        repeat (CPB) @(negedge clock);
        mb[i] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clock);
      last_par = tx;
`endif
      repeat (CPB) @(negedge clock);
      check("stop_bit", {31'd0, tx}, 32'd1);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_frame: got %02h expected no frame", mb);
      end else check("rx_byte", {24'd0, mb}, {24'd0, sb.pop_front()});
    end
  end

  initial begin
    int bc, hi_k, s0, lows;
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'hA5, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'hFF, 1'b0};
    repeat (3) tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_count", {27'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_full", {31'd0, wr_full}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      bc = 0;
      write(vecs[i].d);
      check("latency_pre", {31'd0, tx}, 32'd1);
      for (int k = 0; k < FRAME + 10; k++) begin
        tick();
        if (k == 0) check("latency_start", {31'd0, tx}, 32'd0);
        if (tx_busy) bc++;
      end
      check("busy_cycles", bc, FRAME);
`ifdef UART_TX_PARITY_EN
      check("parity", {31'd0, last_par}, {31'd0, vecs[i].p});
`endif
      check("sb_drained", sb.size(), 0);
    end
    s0 = starts.size();
    wr_en = 1'b1;
    wr_data = 8'h41;
    sb.push_back(8'h41);
    tick();
    wr_data = 8'h42;
    sb.push_back(8'h42);
    tick();
    wr_en = 1'b0;
    wait_idle(3 * FRAME, "b2b_done");
    if (starts.size() >= s0 + 2) check("b2b_gap", starts[s0+1] - starts[s0], FRAME);
    else begin
      total++;
      $display("FAIL b2b_gap: got %0d starts expected 2", starts.size() - s0);
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      if (i <= 16) sb.push_back(8'(i));
      tick();
      if (i == 15) check("full_before", {31'd0, wr_full}, 32'd0);
      if (i == 16) check("full_at16", {31'd0, wr_full}, 32'd1);
      if (i == 16) check("ovf_before", {31'd0, overflow}, 32'd0);
      if (i == 17) check("ovf_set", {31'd0, overflow}, 32'd1);
    end
    wr_en = 1'b0;
    check("count_full", {27'd0, fifo_count}, 32'd16);
    wait_idle(18 * FRAME + 50, "burst_done");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    check("idle_reset_tx", {31'd0, tx}, 32'd1);
    mon_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    repeat (8) tick();
    check("mid_busy", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_tx", {31'd0, tx}, 32'd1);
    check("mid_rst_count", {27'd0, fifo_count}, 32'd0);
    check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    lows = 0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      tick();
      if (!tx || tx_busy) lows++;
    end
    check("no_frames_after_rst", lows, 0);
    mon_en = 1'b1;
    bc = 0;
    hi_k = -1;
    wr_en2 = 1'b1;
    wr_data2 = 8'h00;
    tick();
    wr_en2 = 1'b0;
    for (int k = 0; k < FRAME2 + 10; k++) begin
      tick();
      if (tx_busy2) bc++;
      if (tx2 && hi_k < 0) hi_k = k;
    end
    check("stop2_first_high", hi_k, (1 + DB + PB) * CPB);
    check("stop2_busy", bc, FRAME2);
    check("stop2_len", bc - hi_k, 2 * CPB);
    check("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
